// File: rtl/dma_pcie_rc_pkg.sv
// Shared types and first-beat descriptor layout for the PCIe RC completion ingress path.
package dma_pcie_rc_pkg;

  localparam int TREADY_REPL = 22;

  // Bit offsets of the completion descriptor fields within the first beat
  localparam int HDR_ERR_LSB  = 12;
  localparam int HDR_BCNT_LSB = 16;
  localparam int HDR_DONE_BIT = 30;
  localparam int HDR_STAT_LSB = 43;
  localparam int HDR_POIS_BIT = 46;
  localparam int HDR_TAG_LSB  = 64;

  typedef enum logic {RC_SOP, RC_BODY} rc_state_e;

  typedef struct packed {
    logic [7:0]  tag;
    logic [12:0] byte_cnt;
    logic [3:0]  err_code;
    logic [2:0]  cpl_status;
    logic        poisoned;
    logic        req_done;
  } rc_desc_t;

  function automatic logic rc_cpl_is_err(input logic [3:0] err_code,
                                         input logic [2:0] cpl_status,
                                         input logic       poisoned);
    return (err_code != 4'h0) || (cpl_status != 3'h0) || poisoned;
  endfunction

endpackage

// File: rtl/dma_axis_skid2.sv
// Generic 2-entry registered skid buffer: every output, including in_rdy, comes from a flop.
module dma_axis_skid2 #(
  parameter int PAY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAY_W-1:0] in_pay,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [PAY_W-1:0] out_pay,
  output logic             out_vld,
  input  logic             out_rdy
);

  logic [PAY_W-1:0] skid_pay_p0;
  logic             skid_vld_p0;
  logic             acc;
  logic             head_free;
  logic [1:0]       cnt_nxt;

  assign acc       = in_vld & in_rdy;
  assign head_free = ~out_vld | out_rdy;

  always_comb begin
    cnt_nxt = 2'(out_vld) + 2'(skid_vld_p0) + 2'(acc) - 2'(out_vld & out_rdy);
  end

  // Occupancy control: the head slot refills from the skid slot first to keep order
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld     <= 1'b0;
      skid_vld_p0 <= 1'b0;
      in_rdy      <= 1'b0;
    end else begin
      in_rdy <= (cnt_nxt < 2'd2);
      if (head_free) begin
        out_vld     <= skid_vld_p0 | acc;
        skid_vld_p0 <= skid_vld_p0 & acc;
      end else if (acc) begin
        skid_vld_p0 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (head_free) out_pay <= skid_vld_p0 ? skid_pay_p0 : in_pay;
    if (acc && (skid_vld_p0 || !head_free)) skid_pay_p0 <= in_pay;
  end

endmodule

// File: rtl/dma_pcie_rc_ingress_slice.sv
// Registered PCIe RC completion ingress: skid buffering, replicated tready and first-beat snooping.
module dma_pcie_rc_ingress_slice
  import dma_pcie_rc_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 161,
  parameter int MAX_BEATS  = 64,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic [DATA_WIDTH-1:0]   s_rc_tdata,
  input  logic                    s_rc_tlast,
  input  logic [USER_WIDTH-1:0]   s_rc_tuser,
  input  logic [DATA_WIDTH/32-1:0] s_rc_tkeep,
  input  logic                    s_rc_tvalid,
  output logic [TREADY_REPL-1:0]  s_rc_tready,
  output logic [DATA_WIDTH-1:0]   m_rc_tdata,
  output logic                    m_rc_tlast,
  output logic [USER_WIDTH-1:0]   m_rc_tuser,
  output logic [DATA_WIDTH/32-1:0] m_rc_tkeep,
  output logic                    m_rc_tvalid,
  input  logic                    m_rc_tready,
  output logic                    hdr_vld,
  output logic [7:0]              hdr_tag,
  output logic [12:0]             hdr_byte_cnt,
  output logic [3:0]              hdr_err_code,
  output logic [2:0]              hdr_cpl_status,
  output logic                    hdr_poisoned,
  output logic                    hdr_req_done,
  output logic [31:0]             cpl_pkt_cnt,
  output logic [ERR_CNT_W-1:0]    cpl_err_cnt,
  output logic                    proto_err
);

  localparam int KEEP_W = DATA_WIDTH / 32;
  localparam int PAY_W  = DATA_WIDTH + 1 + USER_WIDTH + KEEP_W;
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [BEAT_W-1:0] beat_sat_inc(input logic [BEAT_W-1:0] c);
    return (c >= BEAT_W'(MAX_BEATS)) ? c : c + 1'b1;
  endfunction

  logic             rdy_p0;
  logic             acc_p0;
  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] pay_out;
  rc_desc_t         desc_in;
  logic             desc_err;
  logic [BEAT_W-1:0] beat_nxt;

  rc_state_e        state_p1;
  logic [BEAT_W-1:0] beat_cnt_p1;
  rc_desc_t         hdr_p1;

  assign acc_p0      = s_rc_tvalid & rdy_p0;
  assign s_rc_tready = {TREADY_REPL{rdy_p0}};
  assign pay_in      = {s_rc_tdata, s_rc_tlast, s_rc_tuser, s_rc_tkeep};
  assign {m_rc_tdata, m_rc_tlast, m_rc_tuser, m_rc_tkeep} = pay_out;

  dma_axis_skid2 #(.PAY_W(PAY_W)) u_skid (
    .clk     (user_clk),
    .rst     (user_reset),
    .in_pay  (pay_in),
    .in_vld  (s_rc_tvalid),
    .in_rdy  (rdy_p0),
    .out_pay (pay_out),
    .out_vld (m_rc_tvalid),
    .out_rdy (m_rc_tready)
  );

  always_comb begin
    desc_in.tag        = s_rc_tdata[HDR_TAG_LSB +: 8];
    desc_in.byte_cnt   = s_rc_tdata[HDR_BCNT_LSB +: 13];
    desc_in.err_code   = s_rc_tdata[HDR_ERR_LSB +: 4];
    desc_in.cpl_status = s_rc_tdata[HDR_STAT_LSB +: 3];
    desc_in.poisoned   = s_rc_tdata[HDR_POIS_BIT];
    desc_in.req_done   = s_rc_tdata[HDR_DONE_BIT];
  end

  assign desc_err = rc_cpl_is_err(desc_in.err_code, desc_in.cpl_status, desc_in.poisoned);
  assign beat_nxt = beat_sat_inc(beat_cnt_p1);

  // Framer and statistics, advanced only on s-side accepts
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_p1    <= RC_SOP;
      beat_cnt_p1 <= '0;
      hdr_vld     <= 1'b0;
      cpl_pkt_cnt <= '0;
      cpl_err_cnt <= '0;
      proto_err   <= 1'b0;
    end else begin
      hdr_vld <= 1'b0;
      if (acc_p0) begin
        case (state_p1)
          RC_SOP: begin
            hdr_vld     <= 1'b1;
            cpl_pkt_cnt <= cpl_pkt_cnt + 32'd1;
            if (desc_err) cpl_err_cnt <= err_sat_inc(cpl_err_cnt);
            if (!s_rc_tlast) begin
              state_p1    <= RC_BODY;
              beat_cnt_p1 <= BEAT_W'(1);
            end
          end
          RC_BODY: begin
            beat_cnt_p1 <= beat_nxt;
            if (s_rc_tlast) state_p1 <= RC_SOP;
            else if (beat_nxt >= BEAT_W'(MAX_BEATS)) proto_err <= 1'b1;
          end
          default: state_p1 <= RC_SOP;
        endcase
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (acc_p0 && (state_p1 == RC_SOP)) hdr_p1 <= desc_in;
  end

  assign hdr_tag        = hdr_p1.tag;
  assign hdr_byte_cnt   = hdr_p1.byte_cnt;
  assign hdr_err_code   = hdr_p1.err_code;
  assign hdr_cpl_status = hdr_p1.cpl_status;
  assign hdr_poisoned   = hdr_p1.poisoned;
  assign hdr_req_done   = hdr_p1.req_done;

endmodule

// File: tb/tb_dma_pcie_rc_ingress_slice.sv
// Randomised bench for the RC ingress slice against a queue-based transaction model.
module tb_dma_pcie_rc_ingress_slice;

  localparam int DW  = 512;
  localparam int UW  = 161;
  localparam int KW  = DW / 32;
  localparam int MB  = 64;
  localparam int EW  = 4;
  localparam int PAY = DW + 1 + UW + KW;
  localparam int ERR_MAX = (1 << EW) - 1;

  typedef logic [PAY-1:0] pay_t;

  logic           clk = 1'b0;
  logic           user_reset = 1'b1;
  logic [DW-1:0]  s_rc_tdata = '0;
  logic           s_rc_tlast = 1'b0;
  logic [UW-1:0]  s_rc_tuser = '0;
  logic [KW-1:0]  s_rc_tkeep = '0;
  logic           s_rc_tvalid = 1'b0;
  logic [21:0]    s_rc_tready;
  logic [DW-1:0]  m_rc_tdata;
  logic           m_rc_tlast;
  logic [UW-1:0]  m_rc_tuser;
  logic [KW-1:0]  m_rc_tkeep;
  logic           m_rc_tvalid;
  logic           m_rc_tready = 1'b0;
  logic           hdr_vld;
  logic [7:0]     hdr_tag;
  logic [12:0]    hdr_byte_cnt;
  logic [3:0]     hdr_err_code;
  logic [2:0]     hdr_cpl_status;
  logic           hdr_poisoned;
  logic           hdr_req_done;
  logic [31:0]    cpl_pkt_cnt;
  logic [EW-1:0]  cpl_err_cnt;
  logic           proto_err;

  dma_pcie_rc_ingress_slice #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_BEATS(MB), .ERR_CNT_W(EW)
  ) dut (
    .user_clk(clk), .user_reset(user_reset),
    .s_rc_tdata(s_rc_tdata), .s_rc_tlast(s_rc_tlast), .s_rc_tuser(s_rc_tuser),
    .s_rc_tkeep(s_rc_tkeep), .s_rc_tvalid(s_rc_tvalid), .s_rc_tready(s_rc_tready),
    .m_rc_tdata(m_rc_tdata), .m_rc_tlast(m_rc_tlast), .m_rc_tuser(m_rc_tuser),
    .m_rc_tkeep(m_rc_tkeep), .m_rc_tvalid(m_rc_tvalid), .m_rc_tready(m_rc_tready),
    .hdr_vld(hdr_vld), .hdr_tag(hdr_tag), .hdr_byte_cnt(hdr_byte_cnt),
    .hdr_err_code(hdr_err_code), .hdr_cpl_status(hdr_cpl_status),
    .hdr_poisoned(hdr_poisoned), .hdr_req_done(hdr_req_done),
    .cpl_pkt_cnt(cpl_pkt_cnt), .cpl_err_cnt(cpl_err_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  pay_t        q[$];
  bit          in_pkt = 0;
  int          beats = 0;
  logic [31:0] m_pkt = '0;
  int          m_err = 0;
  bit          m_perr = 0;
  bit          m_hvld = 0;
  bit          m_rdy = 0;
  bit          hdr_known = 0;
  logic [30:0] m_hdr = '0;
  bit          last_acc = 0;
  int          n_acc = 0;
  int          n_xf = 0;
  int          n_hvld = 0;

  task automatic chk(input string tag, input logic [767:0] got, input logic [767:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit          acc, xf, err;
    pay_t        pin;
    logic [30:0] fields;
    acc = s_rc_tvalid && s_rc_tready[0];
    xf  = m_rc_tvalid && m_rc_tready;
    pin = {s_rc_tdata, s_rc_tlast, s_rc_tuser, s_rc_tkeep};
    fields = {s_rc_tdata[71:64], s_rc_tdata[28:16], s_rc_tdata[15:12],
              s_rc_tdata[45:43], s_rc_tdata[46], s_rc_tdata[30]};
    err = (s_rc_tdata[15:12] != 0) || (s_rc_tdata[45:43] != 0) || s_rc_tdata[46];
    @(posedge clk);
    #1;
    last_acc = acc && !user_reset;
    if (user_reset) begin
      q.delete();
      in_pkt = 0; beats = 0; m_pkt = '0; m_err = 0; m_perr = 0; m_hvld = 0; m_rdy = 0;
    end else begin
      if (xf) begin
        n_xf++;
        if (q.size() > 0) void'(q.pop_front());
      end
      m_hvld = 0;
      if (acc) begin
        n_acc++;
        q.push_back(pin);
        if (!in_pkt) begin
          m_hvld = 1;
          m_pkt = m_pkt + 1;
          m_hdr = fields;
          hdr_known = 1;
          if (err) m_err = (m_err == ERR_MAX) ? ERR_MAX : m_err + 1;
          if (!pin[UW+KW]) begin in_pkt = 1; beats = 1; end
        end else begin
          beats++;
          if (pin[UW+KW]) in_pkt = 0;
          else if (beats >= MB) m_perr = 1;
        end
      end
      m_rdy = (q.size() < 2);
    end
    if (hdr_vld) n_hvld++;
    chk("tready", s_rc_tready, m_rdy ? 22'h3FFFFF : 22'h0);
    chk("tvalid", m_rc_tvalid, q.size() > 0);
    if (q.size() > 0) chk("beat", {m_rc_tdata, m_rc_tlast, m_rc_tuser, m_rc_tkeep}, q[0]);
    chk("hdr_vld", hdr_vld, m_hvld);
    if (hdr_known)
      chk("hdr", {hdr_tag, hdr_byte_cnt, hdr_err_code, hdr_cpl_status, hdr_poisoned, hdr_req_done}, m_hdr);
    chk("pkt_cnt", cpl_pkt_cnt, m_pkt);
    chk("err_cnt", cpl_err_cnt, m_err);
    chk("proto_err", proto_err, m_perr);
  endtask

  task automatic drive_beat(input logic [7:0] tag, input logic [12:0] bc, input logic [3:0] ec,
                            input logic [2:0] st, input logic po, input logic last);
    logic [191:0] tu;
    for (int i = 0; i < KW; i++) s_rc_tdata[i*32 +: 32] = $urandom();
    s_rc_tdata[71:64] = tag;
    s_rc_tdata[28:16] = bc;
    s_rc_tdata[15:12] = ec;
    s_rc_tdata[45:43] = st;
    s_rc_tdata[46]    = po;
    tu = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    s_rc_tuser  = tu[UW-1:0];
    s_rc_tkeep  = KW'($urandom());
    s_rc_tlast  = last;
    s_rc_tvalid = 1'b1;
  endtask

  task automatic rand_beat(input logic last);
    logic [3:0] ec;
    logic [2:0] st;
    logic       po;
    ec = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0;
    st = ($urandom_range(0, 5) == 0) ? 3'($urandom()) : 3'h0;
    po = ($urandom_range(0, 7) == 0);
    drive_beat(8'($urandom()), 13'($urandom()), ec, st, po, last);
  endtask

  task automatic do_reset();
    user_reset = 1'b1;
    s_rc_tvalid = 1'b0;
    tick();
    user_reset = 1'b0;
    tick();
  endtask

  initial begin
    // Reset hold, then release with an always-valid source and always-ready sink
    m_rc_tready = 1'b1;
    repeat (3) tick();
    chk("rst_tvalid", m_rc_tvalid, 1'b0);
    user_reset = 1'b0;
    tick();
    chk("rel_tready", s_rc_tready, 22'h3FFFFF);
    n_acc = 0; n_xf = 0;
    for (int i = 0; i < 100; i++) begin
      rand_beat(1'b1);
      tick();
    end
    s_rc_tvalid = 1'b0;
    tick();
    chk("thru_acc", n_acc, 100);
    chk("thru_xf", n_xf, 100);

    // Sink stall mid-stream
    for (int i = 0; i < 12; i++) begin
      if (!s_rc_tvalid || last_acc) rand_beat(1'b1);
      m_rc_tready = !(i >= 3 && i < 8);
      tick();
      if (i == 7) chk("stall_full", s_rc_tready, 22'h0);
    end
    s_rc_tvalid = 1'b0;
    repeat (3) tick();

    // Directed header capture on a 4-beat completion
    do_reset();
    n_hvld = 0;
    drive_beat(8'hA5, 13'd256, 4'h0, 3'b000, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_beat(i == 2);
      tick();
    end
    s_rc_tvalid = 1'b0;
    repeat (2) tick();
    chk("hdr_pulses", n_hvld, 1);
    chk("hdr_tag_a5", hdr_tag, 8'hA5);
    chk("hdr_bcnt_256", hdr_byte_cnt, 13'd256);
    chk("pkt_cnt_1", cpl_pkt_cnt, 32'd1);
    chk("err_cnt_0", cpl_err_cnt, 4'd0);

    // Error classification, then saturation
    drive_beat(8'h01, 13'd4, 4'h1, 3'b000, 1'b0, 1'b1); tick();
    drive_beat(8'h02, 13'd4, 4'h0, 3'b000, 1'b1, 1'b1); tick();
    drive_beat(8'h03, 13'd4, 4'h0, 3'b001, 1'b0, 1'b1); tick();
    s_rc_tvalid = 1'b0;
    repeat (2) tick();
    chk("err_cnt_3", cpl_err_cnt, 4'd3);
    for (int i = 0; i < 20; i++) begin
      drive_beat(8'($urandom()), 13'd8, 4'h2, 3'b000, 1'b0, 1'b1);
      tick();
    end
    s_rc_tvalid = 1'b0;
    repeat (2) tick();
    chk("err_cnt_sat", cpl_err_cnt, 4'hF);

    // Over-long packet raises a sticky framing error
    for (int i = 0; i < MB; i++) begin
      rand_beat(1'b0);
      tick();
    end
    s_rc_tvalid = 1'b0;
    tick();
    chk("proto_set", proto_err, 1'b1);
    rand_beat(1'b1); tick();
    drive_beat(8'h5A, 13'd16, 4'h0, 3'b000, 1'b0, 1'b1); tick();
    s_rc_tvalid = 1'b0;
    tick();
    chk("after_long_tag", hdr_tag, 8'h5A);
    chk("proto_sticky", proto_err, 1'b1);

    // Reset while two beats of a packet sit in the buffer
    m_rc_tready = 1'b0;
    rand_beat(1'b0);
    for (int i = 0; i < 6 && n_acc >= 0; i++) begin
      if (last_acc) rand_beat(1'b0);
      tick();
      if (!s_rc_tready[0]) break;
    end
    chk("pre_rst_full", s_rc_tready, 22'h0);
    user_reset = 1'b1;
    s_rc_tvalid = 1'b0;
    tick();
    chk("rst_mid_tvalid", m_rc_tvalid, 1'b0);
    chk("rst_mid_pkt", cpl_pkt_cnt, 32'd0);
    user_reset = 1'b0;
    m_rc_tready = 1'b1;
    tick();
    drive_beat(8'h3C, 13'd32, 4'h0, 3'b000, 1'b0, 1'b1);
    tick();
    s_rc_tvalid = 1'b0;
    chk("post_rst_sop", hdr_vld, 1'b1);
    chk("post_rst_tag", hdr_tag, 8'h3C);
    chk("post_rst_pkt", cpl_pkt_cnt, 32'd1);
    tick();

    // Random traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      if (!s_rc_tvalid || last_acc) begin
        if ($urandom_range(0, 4) == 0) s_rc_tvalid = 1'b0;
        else rand_beat($urandom_range(0, 3) == 0);
      end
      m_rc_tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    s_rc_tvalid = 1'b0;
    m_rc_tready = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
